// File: rtl/row_sum_buffer_pkg.sv
// Shared fixed-point definitions for the softmax row datapath.
package row_sum_buffer_pkg;

  localparam int unsigned SUM_W = 16;

  localparam logic signed [SUM_W-1:0] FX_MAX = 16'sh7FFF;
  localparam logic signed [SUM_W-1:0] FX_MIN = 16'sh8000;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } rsb_state_t;

  // Signed add that clamps to the Q-format extremes instead of wrapping.
  function automatic logic signed [SUM_W-1:0] sat_add(
    input logic signed [SUM_W-1:0] a,
    input logic signed [SUM_W-1:0] b
  );
    logic signed [SUM_W:0] s;
    s = (SUM_W+1)'(a) + (SUM_W+1)'(b);
    if (s[SUM_W] != s[SUM_W-1]) begin
      return s[SUM_W] ? FX_MIN : FX_MAX;
    end
    return s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/row_beat_buffer.sv
// Beat storage for one row: synchronous write, combinational read with write-to-read forwarding.
module row_beat_buffer #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [N*W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [N*W-1:0]             rd_data_c
);

  logic [N*W-1:0] mem [DEPTH];

  // Write port; contents are don't-care after reset so no clearing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port; a same-cycle write to the read address is forwarded.
  always_comb begin
    rd_data_c = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_c = wr_data;
    end
  end

endmodule

// File: rtl/row_sum_buffer.sv
// Accumulates a saturated row sum while buffering the row, then replays the row with the sum attached.
module row_sum_buffer
  import row_sum_buffer_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = SUM_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [$clog2(DEPTH):0]     row_beats,
  input  logic                       valid_in,
  input  logic [W-1:0]               sum_in,
  input  logic [N*W-1:0]             data_in_flat,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W-1:0]             data_out_flat,
  output logic [W-1:0]               row_sum_out,
  output logic                       last_out,
  output logic                       ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rsb_state_t             state;
  logic [AW-1:0]          cnt;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          rd_addr;
  logic [CW-1:0]          len_q;
  logic [CW-1:0]          cur_len;
  logic signed [W-1:0]    acc;
  logic signed [W-1:0]    acc_next;
  logic [N*W-1:0]         rd_data;
  logic                   wr_en;
  logic                   final_beat;

  // Effective row length: 0 means one beat, anything above DEPTH is clamped.
  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] rb);
    if (rb == '0) begin
      return CW'(1);
    end
    if (rb > CW'(DEPTH)) begin
      return CW'(DEPTH);
    end
    return rb;
  endfunction

  // Datapath steering: write address, read address, running sum, end-of-row detect.
  always_comb begin
    wr_en      = en && valid_in && (state == ST_FILL);
    cur_len    = (cnt == '0) ? clamp_len(row_beats) : len_q;
    final_beat = (CW'(cnt) == (cur_len - CW'(1)));
    acc_next   = sat_add(acc, sum_in);
    rd_addr    = (state == ST_FILL) ? '0 : (rd_ptr + AW'(1));
  end

  row_beat_buffer #(
    .N     (N),
    .W     (W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (cnt),
    .wr_data   (data_in_flat),
    .rd_addr   (rd_addr),
    .rd_data_c (rd_data)
  );

  // Fill/drain control, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_FILL;
      cnt           <= '0;
      rd_ptr        <= '0;
      len_q         <= CW'(1);
      acc           <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      last_out      <= 1'b0;
      ovf_err       <= 1'b0;
      data_out_flat <= '0;
      row_sum_out   <= '0;
    end else if (en) begin
      if (valid_in && !in_ready) begin
        ovf_err <= 1'b1;
      end
      case (state)
        ST_FILL: begin
          if (valid_in) begin
            if (cnt == '0) begin
              len_q <= cur_len;
            end
            acc <= acc_next;
            cnt <= cnt + AW'(1);
            if (final_beat) begin
              state         <= ST_DRAIN;
              row_sum_out   <= acc_next;
              data_out_flat <= rd_data;
              out_valid     <= 1'b1;
              in_ready      <= 1'b0;
              last_out      <= (cur_len == CW'(1));
              rd_ptr        <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (last_out) begin
              state     <= ST_FILL;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              last_out  <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
            end else begin
              rd_ptr        <= rd_addr;
              data_out_flat <= rd_data;
              last_out      <= (CW'(rd_addr) == (len_q - CW'(1)));
            end
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
